// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: carry-save packet accumulator with chunked carry-propagate resolve
module csa_accum_ctrl #(
   parameter int N     = 32,
   parameter int G     = 8,
   parameter int CHUNK = 8,
   parameter int CW    = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_data,
   input  logic           in_last,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N+G-1:0] out_sum,
   output logic [CW-1:0]  out_count,
   output logic           busy
);
   localparam int W   = N + G;
   localparam int NCH = (W + CHUNK - 1) / CHUNK;
   localparam int KW  = $clog2(NCH + 1);

   typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

   state_t         state, state_nx;
   logic [W-1:0]   s, c, r, d, sp, cp, mask, rv;
   logic [KW-1:0]  k;
   logic           cy, acc, last_k;
   logic [CW-1:0]  count;
   logic [CHUNK:0] csum;
   logic [31:0]    sh;

   // chunk adder for the current resolve step; bits past W fall off the shifts
   always_comb begin
      d      = W'(in_data);
      sh     = 32'(k) * CHUNK;
      sp     = s >> sh;
      cp     = c >> sh;
      csum   = (CHUNK+1)'(sp[CHUNK-1:0]) + (CHUNK+1)'(cp[CHUNK-1:0]) + (CHUNK+1)'(cy);
      mask   = W'({CHUNK{1'b1}}) << sh;
      rv     = (r & ~mask) | (W'(csum[CHUNK-1:0]) << sh);
      last_k = (k == KW'(NCH - 1));
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state decode
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, ACCUM: if (acc) state_nx = in_last ? RESOLVE : ACCUM;
         RESOLVE:     if (last_k) state_nx = DONE;
         DONE:        if (out_ready) state_nx = IDLE;
         default:     state_nx = IDLE;
      endcase
   end

   // handshake and status outputs
   always_comb begin
      in_ready  = (state == IDLE) || (state == ACCUM);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
      acc       = in_valid && in_ready;
      out_sum   = r;
      out_count = count;
   end

   // carry-save accumulation, then one chunk of carry propagation per cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s     <= '0;
         c     <= '0;
         r     <= '0;
         k     <= '0;
         cy    <= 1'b0;
         count <= '0;
      end else begin
         case (state)
            IDLE: if (acc) begin
               s     <= d;
               c     <= '0;
               r     <= '0;
               k     <= '0;
               cy    <= 1'b0;
               count <= CW'(1);
            end
            ACCUM: if (acc) begin
               s     <= s ^ c ^ d;
               c     <= ((s & c) | (s & d) | (c & d)) << 1;
               count <= &count ? count : count + 1'b1;
            end
            RESOLVE: begin
               r  <= rv;
               cy <= last_k ? 1'b0 : csum[CHUNK];
               k  <= last_k ? '0 : k + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// tb_csa_accum_ctrl: directed vectors for the carry-save packet accumulator
module tb_csa_accum_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [39:0] out_sum;
   logic [15:0] out_count;
   logic        busy;
   int          nvec = 0;
   int          nerr = 0;
   int          lat;
   logic [39:0] held_sum;
   logic [15:0] held_cnt;

   csa_accum_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [31:0] v, input logic last);
      in_valid = 1'b1;
      in_data  = v;
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // counts cycles from the accept cycle (1) until out_valid is seen
   task automatic wait_done(output int l);
      l = 1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         l++;
         if (out_valid) return;
      end
      l = -1;
   endtask

   task automatic finish_pkt();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic run_pkt(input string tag, input int m, input logic [31:0] v,
                          input logic [39:0] esum, input logic [15:0] ecnt);
      for (int i = 0; i < m; i++) send(v, i == m - 1);
      wait_done(lat);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_sum"}, 64'(out_sum), 64'(esum));
      chk({tag, "_count"}, 64'(out_count), 64'(ecnt));
      finish_pkt();
   endtask

   initial begin
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_sum", 64'(out_sum), 64'd0);
      chk("rst_out_count", 64'(out_count), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      send(32'h5, 1'b1);
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_in_ready", 64'(in_ready), 64'd0);
      wait_done(lat);
      chk("t1_latency", 64'(lat), 64'd6);
      chk("t1_sum", 64'(out_sum), 64'h0000000005);
      chk("t1_count", 64'(out_count), 64'd1);
      finish_pkt();

      run_pkt("t2", 3, 32'hFFFFFFFF, 40'h02FFFFFFFD, 16'd3);
      run_pkt("t3a", 256, 32'hFFFFFFFF, 40'hFFFFFFFF00, 16'd256);
      run_pkt("t3b", 257, 32'hFFFFFFFF, 40'h00FFFFFEFF, 16'd257);

      send(32'd1, 1'b0);
      in_last = 1'b1;
      @(posedge clk);
      #1;
      in_last = 1'b0;
      chk("t4_stray_last", 64'(busy && in_ready), 64'd1);
      @(posedge clk);
      #1;
      send(32'd2, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      send(32'd3, 1'b1);
      wait_done(lat);
      chk("t4_latency", 64'(lat), 64'd6);
      chk("t4_sum", 64'(out_sum), 64'd6);
      chk("t4_count", 64'(out_count), 64'd3);

      held_sum = out_sum;
      held_cnt = out_count;
      in_valid = 1'b1;
      in_data  = 32'h55;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("t5_valid", 64'(out_valid), 64'd1);
         chk("t5_sum", 64'(out_sum), 64'(held_sum));
         chk("t5_count", 64'(out_count), 64'(held_cnt));
         chk("t5_in_ready", 64'(in_ready), 64'd0);
      end
      finish_pkt();
      in_valid = 1'b0;
      chk("t5_idle_busy", 64'(busy), 64'd0);
      chk("t5_idle_in_ready", 64'(in_ready), 64'd1);
      chk("t5_idle_valid", 64'(out_valid), 64'd0);
      chk("t5_no_accept", 64'(out_count), 64'd3);

      send(32'd9, 1'b0);
      send(32'd4, 1'b0);
      chk("t6_pre_busy", 64'(busy), 64'd1);
      #3;
      rst = 1'b1;
      #1;
      chk("t6_rst_busy", 64'(busy), 64'd0);
      chk("t6_rst_valid", 64'(out_valid), 64'd0);
      chk("t6_rst_sum", 64'(out_sum), 64'd0);
      chk("t6_rst_count", 64'(out_count), 64'd0);
      chk("t6_rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_pkt("t6", 1, 32'd7, 40'd7, 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
